// File: rtl/mem_stage.sv
// Memory stage: registers each executed instruction, forwards non-memory results to
// writeback and runs one handshaked data-memory transaction at a time for loads/stores.

package mem_stage_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic      supported;
        logic      store;
        logic      sign;
        mem_size_t size;
    } mem_op_t;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;
    localparam logic [1:0] TRAP_UNSUP    = 2'b11;
endpackage

// One byte lane of the store path; lane 3 carries bits [31:24] (big-endian).
module mem_lane_steer
    import mem_stage_pkg::*;
#(
    parameter int LANE = 0
) (
    input  mem_size_t  size,
    input  logic [1:0] addr_lo,
    input  logic [7:0] word_byte,
    input  logic [7:0] half_byte,
    input  logic [7:0] byte_byte,
    output logic       strb,
    output logic [7:0] wbyte
);
    always_comb begin
        strb  = 1'b1;
        wbyte = word_byte;
        case (size)
            SZ_BYTE: begin
                strb  = (addr_lo == 2'(3 - LANE));
                wbyte = byte_byte;
            end
            SZ_HALF: begin
                strb  = (addr_lo[1] == (LANE < 2));
                wbyte = half_byte;
            end
            default: ;
        endcase
    end
endmodule

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_mem,
    input  logic [1:0]  opcode,
    input  logic [2:0]  op2,
    input  logic [5:0]  op3,
    input  logic [63:0] result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_blocked,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic [31:0] dreq_addr,
    output logic        dreq_we,
    output logic [31:0] dreq_wdata,
    output logic [3:0]  dreq_strb,
    input  logic        dresp_valid,
    input  logic [31:0] dresp_data,
    output logic        wb_valid,
    output logic        wb_write,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic [1:0]  wb_trap
);
    localparam int NUM_LANES = 4;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;

    mem_op_t   dec;
    logic      accept, is_mem, misaligned, start_req;
    logic      cnt_last, complete, timeout;
    logic [4:0] nm_rd;
    logic      nm_write;

    // Transaction context held while the bus is busy
    logic      cur_store, cur_sign;
    mem_size_t cur_size;
    logic [1:0] cur_k;
    logic [4:0] cur_rd;

    mem_size_t steer_size;
    logic [NUM_LANES-1:0]      lane_strb;
    logic [NUM_LANES-1:0][7:0] lane_wdata;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [63:0] ld_data;

    always_comb begin
        dec           = '0;
        dec.supported = 1'b1;
        dec.size      = SZ_WORD;
        case (op3)
            6'h00: dec.size = SZ_WORD;
            6'h01: dec.size = SZ_BYTE;
            6'h02: dec.size = SZ_HALF;
            6'h09: begin dec.size = SZ_BYTE; dec.sign = 1'b1; end
            6'h0A: begin dec.size = SZ_HALF; dec.sign = 1'b1; end
            6'h04: begin dec.size = SZ_WORD; dec.store = 1'b1; end
            6'h05: begin dec.size = SZ_BYTE; dec.store = 1'b1; end
            6'h06: begin dec.size = SZ_HALF; dec.store = 1'b1; end
            default: dec.supported = 1'b0;
        endcase
    end

    assign accept     = (state_q == IDLE) && exe_mem;
    assign is_mem     = (opcode == 2'd3);
    assign misaligned = ((dec.size == SZ_HALF) && result[0]) ||
                        ((dec.size == SZ_WORD) && (result[1:0] != 2'b00));
    assign start_req  = accept && is_mem && dec.supported && !misaligned;

    assign nm_rd    = (opcode == 2'd1) ? 5'd15 : rd;
    assign nm_write = ((opcode == 2'd2) || (opcode == 2'd1) ||
                       ((opcode == 2'd0) && (op2 == 3'd4))) && (nm_rd != 5'd0);

    // Loads always enable the full word; only stores steer lanes
    assign steer_size = dec.store ? dec.size : SZ_WORD;

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        mem_lane_steer #(.LANE(j)) u_lane (
            .size      (steer_size),
            .addr_lo   (result[1:0]),
            .word_byte (store_data[8*j +: 8]),
            .half_byte (store_data[8*(j%2) +: 8]),
            .byte_byte (store_data[7:0]),
            .strb      (lane_strb[j]),
            .wbyte     (lane_wdata[j])
        );
    end

    assign cnt_last = (cnt_q == CNT_LAST);
    assign complete = (state_q == RESP) && dresp_valid;
    // A response in the final cycle still counts as completion
    assign timeout  = (state_q != IDLE) && cnt_last && !complete;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_req) state_d = REQ;
            REQ:  if (cnt_last) state_d = IDLE;
                  else if (dreq_ready) state_d = RESP;
            RESP: if (dresp_valid || cnt_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (cur_k)
            2'd0:    ld_byte = dresp_data[31:24];
            2'd1:    ld_byte = dresp_data[23:16];
            2'd2:    ld_byte = dresp_data[15:8];
            default: ld_byte = dresp_data[7:0];
        endcase
        ld_half = cur_k[1] ? dresp_data[15:0] : dresp_data[31:16];
        case (cur_size)
            SZ_BYTE: ld_data = {{56{cur_sign & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{48{cur_sign & ld_half[15]}}, ld_half};
            default: ld_data = {32'b0, dresp_data};
        endcase
    end

    assign mem_blocked = (state_q != IDLE);
    assign dreq_valid  = (state_q == REQ);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_store  <= 1'b0;
            cur_sign   <= 1'b0;
            cur_size   <= SZ_BYTE;
            cur_k      <= 2'b00;
            cur_rd     <= 5'd0;
            dreq_addr  <= 32'b0;
            dreq_we    <= 1'b0;
            dreq_wdata <= 32'b0;
            dreq_strb  <= 4'b0;
            wb_valid   <= 1'b0;
            wb_write   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 64'b0;
            wb_trap    <= TRAP_NONE;
        end else begin
            state_q  <= state_d;
            wb_valid <= 1'b0;
            wb_write <= 1'b0;
            if (state_q != IDLE) cnt_q <= cnt_q + CW'(1);

            if (accept) begin
                if (!is_mem) begin
                    wb_valid <= 1'b1;
                    wb_write <= nm_write;
                    wb_rd    <= nm_rd;
                    wb_data  <= result;
                    wb_trap  <= TRAP_NONE;
                end else if (!dec.supported || misaligned) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd;
                    wb_data  <= 64'b0;
                    wb_trap  <= dec.supported ? TRAP_MISALIGN : TRAP_UNSUP;
                end else begin
                    cnt_q      <= '0;
                    cur_store  <= dec.store;
                    cur_sign   <= dec.sign;
                    cur_size   <= dec.size;
                    cur_k      <= result[1:0];
                    cur_rd     <= rd;
                    dreq_addr  <= {result[31:2], 2'b00};
                    dreq_we    <= dec.store;
                    dreq_wdata <= lane_wdata;
                    dreq_strb  <= lane_strb;
                end
            end

            if (complete) begin
                wb_valid <= 1'b1;
                wb_write <= !cur_store && (cur_rd != 5'd0);
                wb_rd    <= cur_rd;
                wb_data  <= cur_store ? 64'b0 : ld_data;
                wb_trap  <= TRAP_NONE;
            end else if (timeout) begin
                wb_valid <= 1'b1;
                wb_rd    <= cur_rd;
                wb_data  <= 64'b0;
                wb_trap  <= TRAP_TIMEOUT;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.

module tb_mem_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exe_mem = 1'b0;
    logic [1:0]  opcode = '0;
    logic [2:0]  op2 = '0;
    logic [5:0]  op3 = '0;
    logic [63:0] result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        mem_blocked, dreq_valid, dreq_we;
    logic        dreq_ready = 1'b0;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_strb;
    logic        dresp_valid = 1'b0;
    logic [31:0] dresp_data = '0;
    logic        wb_valid, wb_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [1:0]  wb_trap;

    int n_checks = 0;
    int n_fail = 0;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .exe_mem(exe_mem), .opcode(opcode), .op2(op2),
        .op3(op3), .result(result), .store_data(store_data), .rd(rd),
        .mem_blocked(mem_blocked), .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
        .dreq_addr(dreq_addr), .dreq_we(dreq_we), .dreq_wdata(dreq_wdata),
        .dreq_strb(dreq_strb), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
        .wb_valid(wb_valid), .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_trap(wb_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          req_seen;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        we;
        bit          changed;
        bit          blk_ok;
        bit          wb_seen;
        logic        wr;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [1:0]  trap;
        int          lat;
    } obs_t;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        we;
        bit          st;
        logic        wr;
        logic [63:0] data;
        logic [1:0]  trap;
        int          lat;
    } exp_t;

    // Whole-transaction reference: what the stage should request and write back.
    function automatic void ref_mem(input logic [5:0] f3, input logic [31:0] a,
                                    input logic [31:0] sd, input logic [4:0] r,
                                    input int dr, input int ds, input bit hr,
                                    input logic [31:0] rdata, output exp_t e);
        int sz, off;
        bit ok, sg;
        logic [63:0] v;
        ok = 1; sg = 0; sz = 4;
        e.req = 0; e.st = 0; e.wr = 0; e.data = '0; e.trap = 2'd0; e.lat = 1;
        e.addr = '0; e.strb = '0; e.wdata = '0; e.we = 0;
        case (f3)
            6'h00: sz = 4;
            6'h01: sz = 1;
            6'h02: sz = 2;
            6'h09: begin sz = 1; sg = 1; end
            6'h0A: begin sz = 2; sg = 1; end
            6'h04: begin sz = 4; e.st = 1; end
            6'h05: begin sz = 1; e.st = 1; end
            6'h06: begin sz = 2; e.st = 1; end
            default: ok = 0;
        endcase
        off = int'(a % 4);
        if (!ok) e.trap = 2'd3;
        else if (off % sz != 0) e.trap = 2'd1;
        else begin
            e.req  = 1;
            e.addr = a - 32'(off);
            e.we   = e.st;
            e.strb = e.st ? 4'(((1 << sz) - 1) << (4 - sz - off)) : 4'hF;
            if (sz == 1)      e.wdata = 32'(sd[7:0]) * 32'h0101_0101;
            else if (sz == 2) e.wdata = 32'(sd[15:0]) * 32'h0001_0001;
            else              e.wdata = sd;
            if (hr && (dr + ds + 2 <= TMO)) begin
                e.lat = dr + ds + 3;
                e.wr  = !e.st && (r != 0);
                v = 64'(rdata) >> (8 * (4 - sz - off));
                v = v & ((64'd1 << (8 * sz)) - 64'd1);
                if (sg && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
                e.data = v;
            end else begin
                e.lat  = TMO + 1;
                e.trap = 2'd2;
            end
        end
    endfunction

    // Bus agent: issues one memory op, plays ready/response with the given delays
    // and records what the DUT did. No comparisons here.
    task automatic do_mem(input logic [5:0] f3, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] r, input int dr, input int ds, input bit hr,
                          input logic [31:0] rdata, input bit noise, output obs_t o);
        int rq = 0, rc = 0;
        bit hs = 0;
        o.req_seen = 0; o.changed = 0; o.blk_ok = 1; o.wb_seen = 0;
        o.addr = '0; o.strb = '0; o.wdata = '0; o.we = 0;
        o.wr = 0; o.rd = '0; o.data = '0; o.trap = '0; o.lat = 0;
        @(negedge clk);
        exe_mem = 1; opcode = 2'd3; op3 = f3; op2 = 3'($urandom);
        result = {$urandom, a}; store_data = sd; rd = r;
        dreq_ready = 0; dresp_valid = 0;
        @(negedge clk);
        exe_mem = 0; opcode = 2'($urandom); result = {$urandom, $urandom};
        store_data = $urandom; rd = 5'($urandom);
        o.lat = 1;
        while (o.lat < 40) begin
            if (wb_valid === 1'b1) begin
                o.wb_seen = 1; o.wr = wb_write; o.rd = wb_rd; o.data = wb_data; o.trap = wb_trap;
                if (mem_blocked !== 1'b0) o.blk_ok = 0;
                break;
            end
            if (mem_blocked !== 1'b1) o.blk_ok = 0;
            dreq_ready = 0; dresp_valid = 0; dresp_data = $urandom;
            if (dreq_valid === 1'b1) begin
                if (!o.req_seen) begin
                    o.req_seen = 1; o.addr = dreq_addr; o.strb = dreq_strb;
                    o.wdata = dreq_wdata; o.we = dreq_we;
                end else if ({dreq_addr, dreq_strb, dreq_wdata, dreq_we} !==
                             {o.addr, o.strb, o.wdata, o.we}) o.changed = 1;
                rq++;
                dreq_ready = (rq > dr);
                if (dreq_ready) hs = 1;
                if (noise) dresp_valid = 1'($urandom_range(0, 1));
            end else if (hs && mem_blocked === 1'b1) begin
                dresp_valid = hr && (rc >= ds);
                if (dresp_valid) dresp_data = rdata;
                rc++;
            end
            @(negedge clk);
            o.lat++;
        end
        dreq_ready = 0; dresp_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0; exe_mem = 1; opcode = 2'd2; result = 64'hDEAD; rd = 5'd3;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_blocked, dreq_valid, dreq_we, wb_valid, wb_write} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 00000",
                               {mem_blocked, dreq_valid, dreq_we, wb_valid, wb_write});
        end
        n_checks++;
        if ({dreq_addr, dreq_wdata, dreq_strb, wb_rd, wb_data, wb_trap} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr=%h wdata=%h strb=%h rd=%h data=%h trap=%b required all 0",
                               dreq_addr, dreq_wdata, dreq_strb, wb_rd, wb_data, wb_trap);
        end
        reset = 1; exe_mem = 0;
    endtask

    task automatic test_alu();
        logic [1:0]  ops[4]  = '{2'd2, 2'd1, 2'd0, 2'd0};
        logic [2:0]  sub[4]  = '{3'd0, 3'd0, 3'd4, 3'd2};
        logic [4:0]  rds[4]  = '{5'd5, 5'd0, 5'd0, 5'd9};
        logic [63:0] res[4]  = '{64'h1234, 64'h8000_0000_0000_0040, 64'h77, 64'h99};
        logic [4:0]  erd[4]  = '{5'd5, 5'd15, 5'd0, 5'd9};
        logic        ewr[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exe_mem = 1; opcode = ops[i]; op2 = sub[i]; rd = rds[i]; result = res[i];
            @(negedge clk);
            exe_mem = 0;
            n_checks++;
            if ({wb_valid, wb_write, wb_rd, wb_data, wb_trap, mem_blocked} !==
                {1'b1, ewr[i], erd[i], res[i], 2'b00, 1'b0}) begin
                n_fail++; $display("FAIL alu_%0d: got v=%b w=%b rd=%0d data=%h trap=%b blk=%b required v=1 w=%b rd=%0d data=%h trap=00 blk=0",
                                   i, wb_valid, wb_write, wb_rd, wb_data, wb_trap, mem_blocked, ewr[i], erd[i], res[i]);
            end
            @(negedge clk);
            n_checks++;
            if (wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL alu_pulse_%0d: wb_valid=%b required 0", i, wb_valid);
            end
        end
    endtask

    task automatic test_loads();
        obs_t o;
        do_mem(6'h09, 32'h1003, 32'h0, 5'd8, 0, 0, 1, 32'h0000_00F0, 0, o);
        n_checks++;
        if ({o.wb_seen, o.wr, o.rd, o.data, o.trap} !== {1'b1, 1'b1, 5'd8, 64'hFFFF_FFFF_FFFF_FFF0, 2'b00} || o.lat != 3) begin
            n_fail++; $display("FAIL ldsb: got seen=%b w=%b rd=%0d data=%h trap=%b lat=%0d required 1 1 8 fffffffffffffff0 00 3",
                               o.wb_seen, o.wr, o.rd, o.data, o.trap, o.lat);
        end
        n_checks++;
        if ({o.req_seen, o.addr, o.strb, o.we} !== {1'b1, 32'h1000, 4'hF, 1'b0}) begin
            n_fail++; $display("FAIL ldsb_req: got seen=%b addr=%h strb=%b we=%b required 1 00001000 1111 0",
                               o.req_seen, o.addr, o.strb, o.we);
        end
        do_mem(6'h01, 32'h1003, 32'h0, 5'd8, 0, 0, 1, 32'h0000_00F0, 0, o);
        n_checks++;
        if ({o.wb_seen, o.wr, o.data, o.trap} !== {1'b1, 1'b1, 64'hF0, 2'b00}) begin
            n_fail++; $display("FAIL ldub: got seen=%b w=%b data=%h trap=%b required 1 1 f0 00",
                               o.wb_seen, o.wr, o.data, o.trap);
        end
    endtask

    task automatic test_store_half();
        obs_t o;
        do_mem(6'h06, 32'h2002, 32'h0000_ABCD, 5'd2, 0, 0, 1, 32'h1234_5678, 0, o);
        n_checks++;
        if ({o.req_seen, o.addr, o.strb, o.wdata, o.we} !== {1'b1, 32'h2000, 4'b0011, 32'hABCD_ABCD, 1'b1}) begin
            n_fail++; $display("FAIL sth_req: got addr=%h strb=%b wdata=%h we=%b required 00002000 0011 abcdabcd 1",
                               o.addr, o.strb, o.wdata, o.we);
        end
        n_checks++;
        if ({o.wb_seen, o.wr, o.trap} !== {1'b1, 1'b0, 2'b00} || o.lat != 3) begin
            n_fail++; $display("FAIL sth_wb: got seen=%b w=%b trap=%b lat=%0d required 1 0 00 3",
                               o.wb_seen, o.wr, o.trap, o.lat);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_mem(6'h00, 32'h3001, 32'h0, 5'd4, 0, 0, 1, 32'h0, 0, o);
        n_checks++;
        if ({o.req_seen, o.wb_seen, o.wr, o.trap} !== {1'b0, 1'b1, 1'b0, 2'b01} || o.lat != 1) begin
            n_fail++; $display("FAIL misaligned: got req=%b seen=%b w=%b trap=%b lat=%0d required 0 1 0 01 1",
                               o.req_seen, o.wb_seen, o.wr, o.trap, o.lat);
        end
        do_mem(6'h03, 32'h3000, 32'h0, 5'd4, 0, 0, 1, 32'h0, 0, o);
        n_checks++;
        if ({o.req_seen, o.wb_seen, o.wr, o.trap} !== {1'b0, 1'b1, 1'b0, 2'b11} || o.lat != 1) begin
            n_fail++; $display("FAIL unsupported: got req=%b seen=%b w=%b trap=%b lat=%0d required 0 1 0 11 1",
                               o.req_seen, o.wb_seen, o.wr, o.trap, o.lat);
        end
    endtask

    // Ready held low the whole window; a held ALU op must wait for the trap writeback.
    task automatic test_stall_timeout();
        @(negedge clk);
        exe_mem = 1; opcode = 2'd3; op3 = 6'h00; result = 64'hFFFF_0000_0000_0100;
        rd = 5'd3; dreq_ready = 0;
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clk);
            exe_mem = 1; opcode = 2'd2; result = 64'h55; rd = 5'd4;
            dresp_valid = 1'b1; dresp_data = 32'hCAFE_F00D;
            n_checks++;
            if ({dreq_valid, dreq_addr, dreq_strb, dreq_we, mem_blocked, wb_valid} !==
                {1'b1, 32'h100, 4'hF, 1'b0, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL stall_c%0d: got v=%b addr=%h strb=%b we=%b blk=%b wb=%b required 1 00000100 1111 0 1 0",
                                   c, dreq_valid, dreq_addr, dreq_strb, dreq_we, mem_blocked, wb_valid);
            end
        end
        @(negedge clk);
        dresp_valid = 0;
        n_checks++;
        if ({wb_valid, wb_write, wb_trap, wb_rd, mem_blocked, dreq_valid} !== {1'b1, 1'b0, 2'b10, 5'd3, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL timeout_wb: got v=%b w=%b trap=%b rd=%0d blk=%b dv=%b required 1 0 10 3 0 0",
                               wb_valid, wb_write, wb_trap, wb_rd, mem_blocked, dreq_valid);
        end
        @(negedge clk);
        exe_mem = 0;
        n_checks++;
        if ({wb_valid, wb_write, wb_rd, wb_data, wb_trap} !== {1'b1, 1'b1, 5'd4, 64'h55, 2'b00}) begin
            n_fail++; $display("FAIL held_alu: got v=%b w=%b rd=%0d data=%h trap=%b required 1 1 4 55 00",
                               wb_valid, wb_write, wb_rd, wb_data, wb_trap);
        end
        @(negedge clk);
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL held_alu_pulse: wb_valid=%b required 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ({wb_valid, wb_rd, wb_data, mem_blocked} !== {1'b1, 5'(i), r0, 1'b0}) begin
                    n_fail++; $display("FAIL b2b_alu_%0d: got v=%b rd=%0d data=%h blk=%b required 1 %0d %h 0",
                                       i, wb_valid, wb_rd, wb_data, mem_blocked, i, r0);
                end
            end
            r0 = {$urandom, $urandom};
            exe_mem = 1; opcode = 2'd2; rd = 5'(i + 1); result = r0;
        end
        // load followed by an ALU op held until the load writes back
        @(negedge clk);
        exe_mem = 1; opcode = 2'd3; op3 = 6'h01; result = 64'h40; rd = 5'd7;
        @(negedge clk);
        exe_mem = 1; opcode = 2'd2; result = 64'h1357; rd = 5'd9; dreq_ready = 1;
        n_checks++;
        if ({dreq_valid, mem_blocked} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_req: got dv=%b blk=%b required 1 1", dreq_valid, mem_blocked);
        end
        @(negedge clk);
        dreq_ready = 0; dresp_valid = 1; dresp_data = 32'hAB00_0000;
        @(negedge clk);
        dresp_valid = 0;
        n_checks++;
        if ({wb_valid, wb_rd, wb_data, mem_blocked} !== {1'b1, 5'd7, 64'hAB, 1'b0}) begin
            n_fail++; $display("FAIL b2b_load: got v=%b rd=%0d data=%h blk=%b required 1 7 ab 0",
                               wb_valid, wb_rd, wb_data, mem_blocked);
        end
        @(negedge clk);
        exe_mem = 0;
        n_checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, 64'h1357}) begin
            n_fail++; $display("FAIL b2b_held: got v=%b rd=%0d data=%h required 1 9 1357",
                               wb_valid, wb_rd, wb_data);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        exe_mem = 1; opcode = 2'd3; op3 = 6'h00; result = 64'h200; rd = 5'd6;
        @(negedge clk);
        exe_mem = 0; dreq_ready = 1;
        @(negedge clk);
        dreq_ready = 0; reset = 0;
        n_checks++;
        if ({mem_blocked, dreq_valid} !== 2'b10) begin
            n_fail++; $display("FAIL rmid_resp: got blk=%b dv=%b required 1 0", mem_blocked, dreq_valid);
        end
        @(negedge clk);
        reset = 1; dresp_valid = 1; dresp_data = 32'h1111_2222;
        @(negedge clk);
        dresp_valid = 0;
        n_checks++;
        if ({mem_blocked, dreq_valid, wb_valid} !== 3'b000) begin
            n_fail++; $display("FAIL rmid_late_resp: got blk=%b dv=%b wb=%b required 0 0 0",
                               mem_blocked, dreq_valid, wb_valid);
        end
        // reset while still requesting
        @(negedge clk);
        exe_mem = 1; opcode = 2'd3; op3 = 6'h04; result = 64'h300; rd = 5'd1;
        @(negedge clk);
        exe_mem = 0; reset = 0;
        @(negedge clk);
        reset = 1;
        n_checks++;
        if ({mem_blocked, dreq_valid, wb_valid} !== 3'b000) begin
            n_fail++; $display("FAIL rmid_req: got blk=%b dv=%b wb=%b required 0 0 0",
                               mem_blocked, dreq_valid, wb_valid);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[8] = '{6'h00, 6'h01, 6'h02, 6'h09, 6'h0A, 6'h04, 6'h05, 6'h06};
        obs_t o;
        exp_t e;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [1:0]  oc = 2'($urandom_range(0, 2));
                logic [2:0]  s2 = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom);
                logic [4:0]  r  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                logic [63:0] v  = {$urandom, $urandom};
                logic [4:0]  xr = (oc == 2'd1) ? 5'd15 : r;
                logic        xw = (oc != 2'd0 || s2 == 3'd4) && xr != 0;
                @(negedge clk);
                exe_mem = 1; opcode = oc; op2 = s2; rd = r; result = v;
                @(negedge clk);
                exe_mem = 0;
                n_checks++;
                if ({wb_valid, wb_write, wb_rd, wb_data, wb_trap} !== {1'b1, xw, xr, v, 2'b00}) begin
                    n_fail++; $display("FAIL rnd_alu_%0d: got v=%b w=%b rd=%0d data=%h trap=%b required 1 %b %0d %h 00",
                                       it, wb_valid, wb_write, wb_rd, wb_data, wb_trap, xw, xr, v);
                end
            end else begin
                logic [5:0]  f3 = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
                logic [31:0] a  = $urandom;
                logic [31:0] sd = $urandom;
                logic [31:0] rdat = $urandom;
                logic [4:0]  r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                int dr = $urandom_range(0, 2);
                int ds = $urandom_range(0, 2);
                bit hr = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
                ref_mem(f3, a, sd, r, dr, ds, hr, rdat, e);
                do_mem(f3, a, sd, r, dr, ds, hr, rdat, 1, o);
                n_checks++;
                if (!o.wb_seen || o.lat != e.lat || {o.trap, o.wr, o.rd} !== {e.trap, e.wr, r}) begin
                    n_fail++; $display("FAIL rnd_wb_%0d op3=%h a=%h: got seen=%b lat=%0d trap=%b w=%b rd=%0d required lat=%0d trap=%b w=%b rd=%0d",
                                       it, f3, a, o.wb_seen, o.lat, o.trap, o.wr, o.rd, e.lat, e.trap, e.wr, r);
                end
                n_checks++;
                if (o.req_seen != e.req || !o.blk_ok || o.changed) begin
                    n_fail++; $display("FAIL rnd_ctl_%0d op3=%h a=%h: got req=%b blk_ok=%b changed=%b required req=%b blk_ok=1 changed=0",
                                       it, f3, a, o.req_seen, o.blk_ok, o.changed, e.req);
                end
                if (e.req) begin
                    n_checks++;
                    if ({o.addr, o.strb, o.we} !== {e.addr, e.strb, e.we} || (e.st && o.wdata !== e.wdata)) begin
                        n_fail++; $display("FAIL rnd_req_%0d op3=%h: got addr=%h strb=%b we=%b wdata=%h required %h %b %b %h",
                                           it, f3, o.addr, o.strb, o.we, o.wdata, e.addr, e.strb, e.we, e.wdata);
                    end
                end
                if (e.req && !e.st && e.trap == 2'd0) begin
                    n_checks++;
                    if (o.data !== e.data) begin
                        n_fail++; $display("FAIL rnd_ld_%0d op3=%h a=%h resp=%h: got %h required %h",
                                           it, f3, a, rdat, o.data, e.data);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_store_half();
        test_misaligned();
        test_stall_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
